gcode2bin_stream: RTL
=====================

Name: gcode2bin_stream

Overview:
- Downstream consumer of the binary-to-Gray encoder stage.
- Accepts a val/rdy stream of Gray-coded samples, decodes each to binary and classifies the step from the previous sample as first, up, down or error.
- Counts illegal transitions.
- Output is registered behind a one-entry pipeline buffer, so it can sit between handshaked producer and consumer stages.

Parameters:
- NBITS, 4: Gray/binary sample width; legal range 2..16.
- ERRCNT_NBITS, 8: width of the saturating error counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_val  input  1  input sample valid
- in_rdy  output  1  block can accept a sample this cycle
- in_  input  NBITS  reflected-binary Gray code sample
- out_val  output  1  output entry valid
- out_rdy  input  1  downstream accepts output this cycle
- out  output  NBITS  decoded binary value
- out_dir  output  2  step class: 00 first, 01 up, 10 down, 11 error
- err_count  output  ERRCNT_NBITS  saturating count of error-class samples

Behaviour:
- Reset (synchronous, active-high, one clk edge) clears all state:
  - out_val=0, out=0, out_dir=00, err_count=0
  - prev_val=0, prev_bin=0
- Reset overrides any handshake in the same cycle. Mid-stream reset discards the buffered entry; the next accepted sample is classified "first".
- Handshake:
  - in_rdy = !out_val || out_rdy (combinational; no combinational path from in_val to out_val).
  - Input transfer occurs when in_val && in_rdy; output transfer when out_val && out_rdy.
  - Simultaneous drain and accept in one cycle is legal: the entry is replaced with no bubble.
- Latency: a sample accepted at edge N appears on out/out_dir with out_val=1 after edge N; throughput one sample/cycle.
- While out_val=1 && out_rdy=0: out and out_dir hold stable, in_rdy=0.
- Decode: bin[NBITS-1]=g[NBITS-1]; bin[i]=bin[i+1]^g[i] for i<NBITS-1. Purely combinational ahead of the register.
- Classification on accept (all arithmetic modulo 2^NBITS):
  - prev_val=0 -> 00
  - bin == prev_bin+1 -> 01 (includes wrap from all-ones binary to 0)
  - bin == prev_bin-1 -> 10 (includes wrap from 0 to all-ones)
  - otherwise, including bin == prev_bin -> 11
- State update on accept: prev_val<=1 and prev_bin<=bin, except as modified by the optional feature.
- err_count increments by 1 on each accepted error-class sample and saturates at 2^ERRCNT_NBITS-1. Updated at the same edge the sample is registered.
- After the first accept, out_val stays 1 until drained. out/out_dir retain their last values when out_val=0.

Optional Feature:
- Macro: GCODE2BIN_HOLD_ON_ERR_EN.
- Defined: an error-class sample does not update prev_bin, so the next sample is classified against the last good code. Non-error samples update prev_bin normally.
- Undefined: prev_bin updates on every accepted sample, including errors.
- err_count behaviour is identical either way.

Test Plan:
- Count up, NBITS=4, out_rdy=1: in_ 0000, 0001, 0011, 0010, 0110 -> out 0, 1, 2, 3, 4; out_dir 00, 01, 01, 01, 01; err_count 0; each one cycle after accept.
- Down and wrap:
  - in_ 1000 (bin 15) then 0000 -> out 15, 0; dir 00, 01.
  - Then 1000 -> out 15, dir 10.
  - Then 1001 (bin 14) -> dir 10.
- Errors:
  - in_ 0000 then 0011 (bin 2) -> dir 11, err_count 1.
  - Repeat 0011 -> dir 11, err_count 2.
  - Then 0010 (bin 3): without macro -> dir 01 (vs 2); with macro -> dir 11 (vs 0), err_count 3.
- Backpressure: accept 0001, hold out_rdy=0 for 3 cycles with in_val=1 and in_=0011 -> in_rdy=0, out=1 stable. Raise out_rdy -> same-cycle drain and accept; next cycle out=2, dir 01.
- Saturation, ERRCNT_NBITS=2: six consecutive identical samples -> first dir 00, then five errors; err_count 1, 2, 3, 3, 3.
- Reset mid-stream: after 0001 is buffered, assert reset one cycle -> out_val=0, err_count=0. Next sample 0011 -> out 2, dir 00.

Source files
------------

// File: rtl/gcode2bin_stream.sv
// Gray-code stream decoder: decodes each accepted Gray sample to binary, classifies the
// step from the previous sample, counts illegal steps. Optional GCODE2BIN_HOLD_ON_ERR_EN.
module gcode2bin_stream #(
  parameter int NBITS        = 4,
  parameter int ERRCNT_NBITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [NBITS-1:0]        in_,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [NBITS-1:0]        out,
  output logic [1:0]              out_dir,
  output logic [ERRCNT_NBITS-1:0] err_count
);

  localparam logic [1:0] DIR_FIRST = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_ERR   = 2'b11;

  logic             prev_val;
  logic [NBITS-1:0] prev_bin;
  logic [NBITS-1:0] bin;
  logic [NBITS-1:0] prev_inc;
  logic [NBITS-1:0] prev_dec;
  logic [1:0]       dir;
  logic             accept;
  logic             drain;

  // Handshake: the single buffer entry frees up in the same cycle it drains.
  assign in_rdy = !out_val || out_rdy;
  assign accept = in_val && in_rdy;
  assign drain  = out_val && out_rdy;

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < NBITS; i++) begin
      bin[i] = ^(in_ >> i);
    end
  end

  assign prev_inc = prev_bin + 1'b1;
  assign prev_dec = prev_bin - 1'b1;

  always_comb begin
    dir = DIR_ERR;
    if (!prev_val)             dir = DIR_FIRST;
    else if (bin == prev_inc)  dir = DIR_UP;
    else if (bin == prev_dec)  dir = DIR_DOWN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_val   <= 1'b0;
      out       <= '0;
      out_dir   <= DIR_FIRST;
      err_count <= '0;
      prev_val  <= 1'b0;
      prev_bin  <= '0;
    end else begin
      if (accept) begin
        out_val  <= 1'b1;
        out      <= bin;
        out_dir  <= dir;
        prev_val <= 1'b1;
`ifdef GCODE2BIN_HOLD_ON_ERR_EN
        // Keep the last good code as reference so one glitch costs a single error.
        if (dir != DIR_ERR) prev_bin <= bin;
`else
        prev_bin <= bin;
`endif
        if (dir == DIR_ERR && err_count != {ERRCNT_NBITS{1'b1}}) begin
          err_count <= err_count + 1'b1;
        end
      end else if (drain) begin
        out_val <= 1'b0;
      end
    end
  end

endmodule
